cla_seq_adder_ctrl: RTL and testbench
=====================================

# cla_seq_adder_ctrl

Multi-cycle wide adder controller. It reuses a single 4-bit carry-lookahead slice to add two WIDTH-bit operands one nibble per cycle, least significant first, and carries the ripple between cycles in a register. Valid/ready handshakes sit on both sides. The block sits between a requester issuing wide add operations and the result consumer, trading latency for area.

## Interface
- WIDTH, 16: operand width in bits; must be a multiple of 4 and at least 4. NIBBLES = WIDTH/4.
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- in_valid  in  1: operand request.
- in_ready  out  1: block can accept a request.
- a  in  WIDTH: operand A.
- b  in  WIDTH: operand B.
- cin  in  1: carry-in.
- sub  in  1: subtract request. Present only with CLA_SEQ_SUB_EN.
- out_valid  out  1: result available.
- out_ready  in  1: consumer accepts the result.
- sum  out  WIDTH: result.
- cout  out  1: carry out of bit WIDTH-1.
- ovf  out  1: signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a, the effective b, and the initial carry.
  - Clear the nibble index to 0 and go to RUN.
- RUN:
  - Slice inputs are A[4k+3:4k], B_eff[4k+3:4k] and the carry register, where k is the nibble index.
  - Each cycle, write the slice sum into sum[4k+3:4k], load the slice carry-out into the carry register, and increment k.
  - When k==NIBBLES-1, write the final carry to cout, compute ovf, and go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - When out_ready=1, go to IDLE.
- ovf = (A[W-1] ~^ B_eff[W-1]) & (sum[W-1] ^ A[W-1]).
- in_ready is 1 only in IDLE. in_valid in RUN or DONE is ignored and its operands are not captured.
- Index wrap: k never exceeds NIBBLES-1. WIDTH=4 means a single RUN cycle.
- sum, cout and ovf hold the previous result through IDLE and are only overwritten during the next RUN.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry register 0, index 0.
- Reset mid-RUN or mid-DONE aborts immediately to the reset values. No partial result is presented.
- If the accept edge is T, the nibble k result is registered at edge T+1+k.
- out_valid rises after edge T+NIBBLES. Latency is NIBBLES cycles.
- out_valid falls on the edge where out_valid&&out_ready.
- in_ready rises on that same edge. The earliest next accept is the following edge.
- Minimum initiation interval is NIBBLES+2 cycles.
- out_ready asserted before out_valid has no effect.
- out_ready held low keeps DONE indefinitely.

## Configuration
- Macro CLA_SEQ_SUB_EN.
- Defined:
  - The sub port exists.
  - With sub=1, B_eff=~b and the initial carry is 1; cin is ignored.
  - cout=1 means no borrow.
  - With sub=0, behaviour is identical to the undefined case.
- Undefined:
  - No sub port.
  - B_eff=b and the initial carry is cin.

## Structure
- Package cla_seq_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - NIBBLE_W=4;
  - the index width function clog2(NIBBLES), minimum 1.
- One sub-module: the existing 4-bit carry-lookahead slice CLA_4bit, instantiated once.
- The controller holds the FSM, index counter, carry register, operand registers and result register.

## Test plan
- Basic add, WIDTH=16: a=0x1234, b=0x0FCD, cin=0 -> sum=0x2201, cout=0, ovf=0. out_valid exactly 4 cycles after the accept edge.
- Full ripple: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - sum, out_valid and in_ready stay stable.
  - A new in_valid with a=0x1111 is ignored.
  - After out_ready=1, the first result completes and is unchanged.
- Reset asserted in the 2nd RUN cycle -> all outputs at reset values next cycle. A fresh 0x0001+0x0001 then yields 0x0002.
- With CLA_SEQ_SUB_EN: a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// Shared types and sizing helpers for the sequential carry-lookahead adder controller.
// Build option: CLA_SEQ_SUB_EN adds a subtract request port to the controller.
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // Bits needed to index the nibbles; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < nibbles) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_cla4.sv
// 4-bit carry-lookahead adder slice; purely combinational, all carries from generate/propagate.
module CLA_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Wide adder that reuses one CLA_4bit slice, one nibble per cycle LSB first; latency WIDTH/4 cycles.
// Valid/ready on both sides; DONE holds the result until out_ready. CLA_SEQ_SUB_EN adds the sub port.
module cla_seq_adder_ctrl
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   b_eff;
    logic               carry_init;
    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic               slice_co;

    // Subtraction is two's complement: invert B and force the initial carry.
`ifdef CLA_SEQ_SUB_EN
    assign b_eff      = sub ? ~b : b;
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign b_eff      = b;
    assign carry_init = cin;
`endif

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                slice_a = a_q[k*NIBBLE_W +: NIBBLE_W];
                slice_b = b_q[k*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    CLA_4bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_s),
        .cout (slice_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = carry_init;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < NIBBLES; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        sum_d[k*NIBBLE_W +: NIBBLE_W] = slice_s;
                    end
                end
                carry_d = slice_co;
                if (idx_q == LAST_IDX) begin
                    // The top nibble is being written now, so its MSB comes from the slice.
                    cout_d  = slice_co;
                    ovf_d   = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (slice_s[NIBBLE_W-1] ^ a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Randomised and directed bench for cla_seq_adder_ctrl against an arithmetic reference model.
module tb_cla_seq_adder_ctrl;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub_r;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks;
    int errors;

    cla_seq_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete operation: accept, latency, result, optional backpressure, release.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input logic ts, input int hold, input logic early);
        logic [W-1:0] beff;
        logic         c0;
        logic [W:0]   r;
        logic         exp_ovf;
        beff    = ts ? ~tb_ : tb_;
        c0      = ts ? 1'b1 : tc;
        r       = {1'b0, ta} + {1'b0, beff} + {{W{1'b0}}, c0};
        exp_ovf = (ta[W-1] == beff[W-1]) && (r[W-1] != ta[W-1]);

        @(negedge clk);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb_;
        cin       = tc;
        sub_r     = ts;
        out_ready = early;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        repeat (N - 1) @(posedge clk);
        #1;
        chk("valid_not_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("valid_at_latency", {31'd0, out_valid}, 32'd1);
        chk("sum", {16'd0, sum}, {16'd0, r[W-1:0]});
        chk("cout", {31'd0, cout}, {31'd0, r[W]});
        chk("ovf", {31'd0, ovf}, {31'd0, exp_ovf});

        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a         = 16'h1111;
            b         = 16'h1111;
            repeat (hold) @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_sum", {16'd0, sum}, {16'd0, r[W-1:0]});
            in_valid = 1'b0;
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", {31'd0, out_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_sum_held", {16'd0, sum}, {16'd0, r[W-1:0]});
        chk("idle_cout_held", {31'd0, cout}, {31'd0, r[W]});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub_r     = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 0, 1'b1);
        do_op(16'hABCD, 16'h1357, 1'b1, 1'b0, 5, 1'b0);

        // Abort in the second RUN cycle: reset clears everything, including the prior result.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 16'h1234;
        b        = 16'h0FCD;
        cin      = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_sum", {16'd0, sum}, 32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_abort_idle", {31'd0, out_valid}, 32'd0);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

`ifdef CLA_SEQ_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0);
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            logic s;
`ifdef CLA_SEQ_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            do_op(W'($urandom), W'($urandom), 1'($urandom), s,
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
